ready_queue_agent: RTL and testbench



---
 rtl/ready_queue_agent_pkg.sv | 40 ++++
 rtl/ready_queue_agent_edf_min_select.sv | 31 +++
 rtl/ready_queue_agent.sv | 178 +++++++++++++++++
 tb/tb_ready_queue_agent.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ready_queue_agent_pkg.sv
// Scheduler-wide shared types: default widths, table entry layout, controller phase codes.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package ready_queue_agent_pkg;

    localparam int ID_W_DEF = 8;
    localparam int DL_W_DEF = 16;
    localparam int N_DEF    = 8;

    // One pending task as held by queue blocks at default widths.
    typedef struct packed {
        logic                valid;
        logic [ID_W_DEF-1:0] id;
        logic [DL_W_DEF-1:0] deadline;
    } entry_t;

    // Controller phase as seen by a responder; action outranks the rest.
    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_INSERT   = 3'd1,
        PH_SUBTRACT = 3'd2,
        PH_REPAIR   = 3'd3,
        PH_ACTION   = 3'd4
    } phase_t;

    // Collapse the raw control strobes into a single phase code.
    function automatic phase_t decode_phase(input logic action,
                                            input logic subtract,
                                            input logic repair_period,
                                            input logic mq_active);
        phase_t ph;
        if (action)             ph = PH_ACTION;
        else if (subtract)      ph = PH_SUBTRACT;
        else if (repair_period) ph = PH_REPAIR;
        else if (mq_active)     ph = PH_INSERT;
        else                    ph = PH_IDLE;
        return ph;
    endfunction

endpackage

// File: rtl/ready_queue_agent_edf_min_select.sv
// Earliest-deadline selector: index of the valid entry with the smallest deadline, lowest index on ties.
// Latency: purely combinational.
// Backpressure: none; found=0 when no entry is valid.
module edf_min_select #(
    parameter int N     = 8,
    parameter int DL_W  = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]      valid,
    input  logic [N*DL_W-1:0] deadlines,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    logic [DL_W-1:0] best;

    // Ascending scan with strict less-than so an equal later deadline never displaces an earlier slot.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        best  = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (!found || (deadlines[i*DL_W +: DL_W] < best))) begin
                found = 1'b1;
                idx   = IDX_W'(i);
                best  = deadlines[i*DL_W +: DL_W];
            end
        end
    end

endmodule

// File: rtl/ready_queue_agent.sv
// Ready-queue responder: N-slot task table with insert, frame aging, repair-window purge and EDF dispatch.
// Latency: insert/dispatch/purge take effect on the next edge; disp_* is combinational from the table.
// Backpressure: ins_ready drops outside the insert phase or when full; a candidate is held until disp_ready.
module ready_queue_agent
    import ready_queue_agent_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int ID_W = ID_W_DEF,
    parameter int DL_W = DL_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     action,
    input  logic                     subtract,
    input  logic                     repair_period,
    input  logic                     MQ_active,
    input  logic                     ins_valid,
    input  logic [ID_W-1:0]          ins_id,
    input  logic [DL_W-1:0]          ins_deadline,
    output logic                     ins_ready,
    output logic                     disp_valid,
    output logic [ID_W-1:0]          disp_id,
    output logic [DL_W-1:0]          disp_deadline,
    input  logic                     disp_ready,
    output logic                     miss_valid,
    output logic [ID_W-1:0]          miss_id,
    output logic [$clog2(N+1)-1:0]   count,
    output logic                     protocol_err
);

    localparam int CNT_W = $clog2(N+1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]      slot_vld;
    logic [ID_W-1:0]   slot_id [N];
    logic [DL_W-1:0]   slot_dl [N];
    logic [N*DL_W-1:0] dl_flat;

    phase_t            phase;
    logic              rep_prev;
    logic              sub_prev;
    logic              rep_rise;
    logic              scan_en;
    logic [IDX_W-1:0]  scan_ptr;
    logic [IDX_W-1:0]  scan_cur;
    logic [IDX_W-1:0]  scan_nxt;
    logic              purge;

    logic [IDX_W-1:0]  free_idx;
    logic              free_found;
    logic [IDX_W-1:0]  min_idx;
    logic              min_found;
    logic              ins_fire;
    logic              disp_fire;
    logic              violation;

    assign phase     = decode_phase(action, subtract, repair_period, MQ_active);
    assign ins_ready = (phase == PH_INSERT) && (count < CNT_W'(N));
    assign ins_fire  = ins_valid && ins_ready && free_found;

    // Lowest-index free slot; descending loop so the last hit is the lowest index.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = N-1; i >= 0; i--) begin
            if (!slot_vld[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    // Flatten deadlines for the shared selector.
    always_comb begin
        dl_flat = '0;
        for (int i = 0; i < N; i++) begin
            dl_flat[i*DL_W +: DL_W] = slot_dl[i];
        end
    end

    edf_min_select #(
        .N     (N),
        .DL_W  (DL_W),
        .IDX_W (IDX_W)
    ) u_edf_min_select (
        .valid     (slot_vld),
        .deadlines (dl_flat),
        .idx       (min_idx),
        .found     (min_found)
    );

    assign disp_valid    = action && min_found;
    assign disp_id       = slot_id[min_idx];
    assign disp_deadline = slot_dl[min_idx];
    assign disp_fire     = disp_valid && disp_ready;

    // The first repair cycle examines slot 0 directly, so the restart does not cost a cycle.
    // Action has priority: the scan neither examines nor advances while action is high.
    assign rep_rise = repair_period && !rep_prev;
    assign scan_cur = rep_rise ? '0 : scan_ptr;
    assign scan_nxt = (scan_cur == IDX_W'(N-1)) ? '0 : scan_cur + IDX_W'(1);
    assign scan_en  = repair_period && !action;
    assign purge    = scan_en && slot_vld[scan_cur] && (slot_dl[scan_cur] == '0);

    assign violation = (action && (MQ_active || subtract || repair_period)) || (subtract && sub_prev);

    // Task table: aging, purge, dispatch and insert; purge compares against pre-decrement deadlines.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
            for (int i = 0; i < N; i++) begin
                slot_id[i] <= '0;
                slot_dl[i] <= '0;
            end
        end else begin
            if (subtract) begin
                for (int i = 0; i < N; i++) begin
                    if (slot_vld[i] && (slot_dl[i] != '0)) begin
                        slot_dl[i] <= slot_dl[i] - DL_W'(1);
                    end
                end
            end
            if (purge) begin
                slot_vld[scan_cur] <= 1'b0;
            end
            if (disp_fire) begin
                slot_vld[min_idx] <= 1'b0;
            end
            if (ins_fire) begin
                slot_vld[free_idx] <= 1'b1;
                slot_id[free_idx]  <= ins_id;
                slot_dl[free_idx]  <= ins_deadline;
            end
        end
    end

    // Occupancy tracks the net of insert, dispatch and purge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(ins_fire) - CNT_W'(disp_fire) - CNT_W'(purge);
        end
    end

    // Repair scan pointer and phase edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_ptr <= '0;
            rep_prev <= 1'b0;
            sub_prev <= 1'b0;
        end else begin
            rep_prev <= repair_period;
            sub_prev <= subtract;
            if (scan_en) begin
                scan_ptr <= scan_nxt;
            end else if (rep_rise) begin
                scan_ptr <= '0;
            end
        end
    end

    // One-cycle miss report and sticky phase-violation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_valid   <= 1'b0;
            miss_id      <= '0;
            protocol_err <= 1'b0;
        end else begin
            miss_valid <= purge;
            miss_id    <= purge ? slot_id[scan_cur] : '0;
            if (violation) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ready_queue_agent.sv
// Self-checking bench: directed phase sequences with a dispatch/miss scoreboard checked by a monitor.
// Latency: expectations assume next-edge table updates and combinational dispatch outputs.
// Backpressure: disp_ready driven only inside dispatch windows.
module tb_ready_queue_agent;

    logic        clk = 1'b0;
    logic        rst;
    logic        action, subtract, repair_period, MQ_active;
    logic        ins_valid;
    logic [7:0]  ins_id;
    logic [15:0] ins_deadline;
    logic        ins_ready;
    logic        disp_valid;
    logic [7:0]  disp_id;
    logic [15:0] disp_deadline;
    logic        disp_ready;
    logic        miss_valid;
    logic [7:0]  miss_id;
    logic [3:0]  count;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  id;
        logic [15:0] dl;
    } disp_exp_t;

    disp_exp_t  dq[$];
    logic [7:0] mq[$];
    disp_exp_t  de;
    logic [7:0] me;

    always #5 clk = ~clk;

    ready_queue_agent #(.N(8), .ID_W(8), .DL_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .action        (action),
        .subtract      (subtract),
        .repair_period (repair_period),
        .MQ_active     (MQ_active),
        .ins_valid     (ins_valid),
        .ins_id        (ins_id),
        .ins_deadline  (ins_deadline),
        .ins_ready     (ins_ready),
        .disp_valid    (disp_valid),
        .disp_id       (disp_id),
        .disp_deadline (disp_deadline),
        .disp_ready    (disp_ready),
        .miss_valid    (miss_valid),
        .miss_id       (miss_id),
        .count         (count),
        .protocol_err  (protocol_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called at posedge+1 with MQ_active already high; returns at posedge+1 after the write.
    task automatic do_ins(input logic [7:0] id, input logic [15:0] dl);
        ins_valid    = 1'b1;
        ins_id       = id;
        ins_deadline = dl;
        @(posedge clk); #1;
        ins_valid    = 1'b0;
    endtask

    task automatic do_disp(input int n);
        action     = 1'b1;
        disp_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        action     = 1'b0;
        disp_ready = 1'b0;
    endtask

    task automatic push_disp(input logic [7:0] id, input logic [15:0] dl);
        disp_exp_t e;
        e.id = id;
        e.dl = dl;
        dq.push_back(e);
    endtask

    task automatic pulse_subtract();
        subtract = 1'b1;
        @(posedge clk); #1;
        subtract = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_repair(input int n);
        repair_period = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        repair_period = 1'b0;
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every accepted dispatch and every miss pulse must match the next expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (disp_valid && disp_ready) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL disp_unexpected actual_id=%0d expected=none", disp_id);
                end else begin
                    de = dq.pop_front();
                    if (disp_id !== de.id || disp_deadline !== de.dl) begin
                        errors++;
                        $display("FAIL disp actual=%0d/%0d expected=%0d/%0d",
                                 disp_id, disp_deadline, de.id, de.dl);
                    end
                end
            end
            if (miss_valid) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL miss_unexpected actual_id=%0d expected=none", miss_id);
                end else begin
                    me = mq.pop_front();
                    if (miss_id !== me) begin
                        errors++;
                        $display("FAIL miss actual=%0d expected=%0d", miss_id, me);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; action = 1'b0; subtract = 1'b0; repair_period = 1'b0; MQ_active = 1'b0;
        ins_valid = 1'b0; ins_id = '0; ins_deadline = '0; disp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_disp_valid", 32'(disp_valid), 0);
        chk("rst_miss_valid", 32'(miss_valid), 0);
        chk("rst_protocol_err", 32'(protocol_err), 0);
        chk("rst_ins_ready_closed", 32'(ins_ready), 0);
        MQ_active = 1'b1; #1;
        chk("ins_ready_open", 32'(ins_ready), 1);

        // EDF order with tie to lowest slot
        do_ins(8'd1, 16'd5);
        do_ins(8'd2, 16'd2);
        do_ins(8'd3, 16'd2);
        chk("count_after_3", 32'(count), 3);
        MQ_active = 1'b0;
        push_disp(8'd2, 16'd2);
        push_disp(8'd3, 16'd2);
        push_disp(8'd1, 16'd5);
        do_disp(3);
        chk("count_after_drain", 32'(count), 0);

        // Full table, then refill into the freed slot
        MQ_active = 1'b1;
        do_ins(8'd10, 16'd60); do_ins(8'd11, 16'd50); do_ins(8'd12, 16'd40); do_ins(8'd13, 16'd30);
        do_ins(8'd14, 16'd20); do_ins(8'd15, 16'd25); do_ins(8'd16, 16'd35); do_ins(8'd17, 16'd45);
        chk("count_full", 32'(count), 8);
        ins_valid = 1'b1; ins_id = 8'd77; ins_deadline = 16'd1; #1;
        chk("ins_ready_full", 32'(ins_ready), 0);
        @(posedge clk); #1;
        ins_valid = 1'b0;
        chk("count_still_full", 32'(count), 8);
        MQ_active = 1'b0;
        push_disp(8'd14, 16'd20);
        do_disp(1);
        chk("count_after_one_disp", 32'(count), 7);
        MQ_active = 1'b1;
        do_ins(8'd99, 16'd25);
        MQ_active = 1'b0;
        chk("count_refill", 32'(count), 8);
        push_disp(8'd99, 16'd25); push_disp(8'd15, 16'd25); push_disp(8'd13, 16'd30);
        push_disp(8'd16, 16'd35); push_disp(8'd12, 16'd40); push_disp(8'd17, 16'd45);
        push_disp(8'd11, 16'd50); push_disp(8'd10, 16'd60);
        do_disp(8);
        chk("count_after_full_drain", 32'(count), 0);

        // Aging to zero then purge in a long repair window
        MQ_active = 1'b1;
        do_ins(8'd42, 16'd1);
        do_ins(8'd43, 16'd9);
        MQ_active = 1'b0;
        pulse_subtract();
        mq.push_back(8'd42);
        run_repair(32);
        chk("count_after_purge", 32'(count), 1);
        push_disp(8'd43, 16'd8);
        do_disp(1);
        chk("count_after_aged_disp", 32'(count), 0);

        // Zero deadline saturates under subtract and is purged
        MQ_active = 1'b1;
        do_ins(8'd50, 16'd0);
        do_ins(8'd51, 16'd3);
        MQ_active = 1'b0;
        pulse_subtract();
        mq.push_back(8'd50);
        run_repair(8);
        chk("count_after_sat_purge", 32'(count), 1);
        push_disp(8'd51, 16'd2);
        do_disp(1);

        // Sticky protocol error
        chk("protocol_err_clean", 32'(protocol_err), 0);
        action = 1'b1; MQ_active = 1'b1;
        @(posedge clk); #1;
        action = 1'b0; MQ_active = 1'b0;
        chk("protocol_err_set", 32'(protocol_err), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("protocol_err_sticky", 32'(protocol_err), 1);

        // Reset in the middle of a repair window
        MQ_active = 1'b1;
        do_ins(8'd60, 16'd5); do_ins(8'd61, 16'd6); do_ins(8'd62, 16'd7); do_ins(8'd63, 16'd8);
        MQ_active = 1'b0;
        chk("count_before_rst", 32'(count), 4);
        repair_period = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; repair_period = 1'b0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_miss_valid", 32'(miss_valid), 0);
        chk("midrst_protocol_err", 32'(protocol_err), 0);
        action = 1'b1; #1;
        chk("midrst_disp_valid", 32'(disp_valid), 0);
        @(posedge clk); #1;
        action = 1'b0;
        MQ_active = 1'b1; #1;
        chk("midrst_ins_ready", 32'(ins_ready), 1);
        MQ_active = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("disp_queue_drained", 32'(dq.size()), 0);
        chk("miss_queue_drained", 32'(mq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
